store_buffer: RTL
=================

# store_buffer

Write-side counterpart of the load-data alignment path in the RV32I pipeline. Accepts `sb`/`sh`/`sw` stores from the MEM stage, converts each into a word-aligned address, a lane-shifted write word and a byte mask, and queues them in a small FIFO. It drains the FIFO to the data cache one write at a time over the `dcache_write`/`dcache_resp` handshake. It also flags later loads whose word address matches any pending store.

## Interface
- `DEPTH`, 4: number of buffered stores; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  MEM stage presents a store.
- `st_funct3`  in  3  store width: `storewidth::sb`=000, `sh`=001, `sw`=010.
- `st_addr`  in  32  byte address.
- `st_data`  in  32  raw rs2 value, unshifted.
- `st_ready`  out  1  the buffer can accept a store this cycle.
- `st_misaligned`  out  1  the presented store is misaligned.
- `ld_addr`  in  32  byte address of the load in MEM.
- `ld_conflict`  out  1  the load word matches a pending store.
- `dcache_write`  out  1  write request.
- `dcache_address`  out  32  word-aligned address, bits [1:0] = 0.
- `dcache_wdata`  out  32  lane-shifted data.
- `dcache_mbe`  out  4  byte enables.
- `dcache_resp`  in  1  one-cycle completion pulse.
- `empty`  out  1  no stores pending; used for fence and halt.

## Operation
- **Alignment:** take `off` = `st_addr[1:0]`.
  - `wdata` = `st_data << (8*off)`.
  - `mbe`: `sb` gives `4'b0001 << off`; `sh` gives `4'b0011 << off`; `sw` gives `4'b1111`.
  - Address = `{st_addr[31:2], 2'b00}`.
- **Misaligned stores:** `sh` with `off[0]`=1, `sw` with `off`≠0, or any other funct3.
  - `st_misaligned` is asserted combinationally while `st_valid` is high.
  - The store is never enqueued, even when `st_ready` is high.
- **Enqueue:** when `st_valid & st_ready & ~st_misaligned`, write `{addr, wdata, mbe}` at the tail.
- **`st_ready`** = `~full`. It is registered-state based only; there is no same-cycle pass-through on dequeue.
- **Drain FSM:**
  - `IDLE`: the FIFO is empty and `dcache_write` = 0. Move to `WRITE` on the cycle after the first enqueue.
  - `WRITE`: `dcache_write` = 1 and the address/data/mbe outputs are driven from the head entry, stable until `dcache_resp`.
  - On `dcache_resp`, pop the head. If the FIFO is not then empty, stay in `WRITE` and present the next head in the following cycle (back-to-back allowed). Otherwise go to `IDLE`.
  - `dcache_resp` is ignored in `IDLE`.
- **Simultaneous enqueue and pop:** count is unchanged; the pointers advance independently and wrap modulo `DEPTH`.
- **Load conflict:** `ld_conflict` is combinational. It is 1 if `ld_addr[31:2]` equals the word address of any valid entry, or of a store being enqueued this cycle. The comparison is word-granular, conservative, and ignores the mask.
- **`empty`** = (count == 0).

## Timing
- **Reset values:** `dcache_write`=0, `dcache_address`=0, `dcache_wdata`=0, `dcache_mbe`=0, `empty`=1, `st_ready`=1. Count, pointers and all entry valid bits are 0. FSM is in `IDLE`.
- **Reset mid-write:** all pending stores are discarded and `dcache_write` is 0 in the first cycle after the reset edge. A `dcache_resp` in that cycle is ignored.
- **Latency:** a store accepted in cycle t raises `dcache_write` at t+1 if the buffer was empty. Otherwise it raises it after all earlier entries complete. Strict FIFO order.
- **Throughput:** one completed write per `dcache_resp`. The minimum gap between writes is 0 cycles.
- **Full:** count == `DEPTH` drives `st_ready` low. A pop in the same cycle does not raise it until the next cycle.
- **Outputs in `IDLE`:** `dcache_address`/`wdata`/`mbe` are 0.

## Structure
- Package `storewidth`: enum `storewidth_sel_t` (`sb`, `sh`, `sw`, matching funct3), plus localparams for the mbe patterns.
- Package `sbstate`: enum `sb_state_t` (`IDLE`, `WRITE`).
- Sub-module `store_align`: combinational; takes funct3, offset and data; produces wdata, mbe and misaligned. It is instantiated once before the FIFO.
- FIFO storage, pointers, counter, FSM and the conflict comparators live in `store_buffer`.

## Test plan
- **`sb` lane placement:** `sb` at 0x00001003 with data 0x000000AB → `dcache_address` 0x00001000, `dcache_wdata` 0xAB000000, `dcache_mbe` 4'b1000. `dcache_write` rises the cycle after acceptance.
- **`sh` lane placement:** `sh` at 0x00000102 with data 0xFFFF1234 → `dcache_wdata` 0x12340000, `dcache_mbe` 4'b1100.
- **Full buffer:** hold `dcache_resp`=0 and issue 4 `sw` stores → `st_ready`=0 after the 4th. A 5th `st_valid` is not accepted. Then 4 `dcache_resp` pulses drain the stores in order, back-to-back, and `empty`=1 afterwards.
- **Simultaneous enqueue and pop:** at count 2, accept a store in the same cycle as `dcache_resp` → count stays 2 and the next head is the second-oldest store.
- **Conflict and misaligned:** with `sw` to 0x2000 pending, `ld_addr`=0x2002 gives `ld_conflict`=1 and `ld_addr`=0x2004 gives 0. `sh` at 0x101 gives `st_misaligned`=1 and count is unchanged.
- **Reset mid-write:** assert `rst` while in `WRITE` with 3 entries → next cycle `dcache_write`=0, `empty`=1, `st_ready`=1.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store widths, drain states and the
// layout of one buffered store entry.

package storewidth;

  // Store width selector, encoded exactly as the RV32I store funct3 field.
  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } storewidth_sel_t;

  // Byte-enable patterns before they are shifted into their lane.
  localparam logic [3:0] MBE_BYTE = 4'b0001;
  localparam logic [3:0] MBE_HALF = 4'b0011;
  localparam logic [3:0] MBE_WORD = 4'b1111;

endpackage

package sbstate;

  // Drain FSM: IDLE while nothing is pending, WRITE while the head entry
  // is being offered to the data cache.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sb_state_t;

endpackage

package store_buffer_pkg;

  // One buffered store. Only the word address is kept, because every
  // cache write is word aligned and the lane is already encoded in mbe.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } sb_entry_t;

  // Width of a pointer into a buffer of the given depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_buffer_align.sv
// Store alignment: moves the raw rs2 value into its byte lane, builds the
// byte mask and detects stores that cannot be issued as a single write.

module store_align
  import storewidth::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  mbe,
  output logic        misaligned
);

  // The data shift is the same for every width; the upper bytes that fall
  // outside the mask are simply not written by the cache.
  always_comb begin
    wdata = data << {offset, 3'b000};
  end

  // Mask and misalignment depend on the width; unknown funct3 values are
  // treated as misaligned so they are never enqueued.
  always_comb begin
    mbe        = 4'b0000;
    misaligned = 1'b1;
    case (funct3)
      sb: begin
        mbe        = MBE_BYTE << offset;
        misaligned = 1'b0;
      end
      sh: begin
        mbe        = MBE_HALF << offset;
        misaligned = offset[0];
      end
      sw: begin
        mbe        = MBE_WORD;
        misaligned = (offset != 2'b00);
      end
      default: begin
        mbe        = 4'b0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns MEM-stage stores, queues them in a small FIFO and
// drains them to the data cache one write at a time. Also flags loads that
// hit the word of any store still waiting in the buffer.

module store_buffer
  import storewidth::*;
  import sbstate::*;
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_misaligned,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        dcache_write,
  output logic [31:0] dcache_address,
  output logic [31:0] dcache_wdata,
  output logic [3:0]  dcache_mbe,
  input  logic        dcache_resp,
  output logic        empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  sb_state_t        state_q, state_d;

  // Aligned view of the presented store
  logic [31:0] align_wdata;
  logic [3:0]  align_mbe;
  logic        align_misaligned;

  logic full;
  logic push;
  logic pop;

  // The load's byte offset does not matter for a word-granular match.
  logic unused_ld_offset;
  assign unused_ld_offset = ^ld_addr[1:0];

  store_align u_align (
    .funct3     (st_funct3),
    .offset     (st_addr[1:0]),
    .data       (st_data),
    .wdata      (align_wdata),
    .mbe        (align_mbe),
    .misaligned (align_misaligned)
  );

  // Handshake decode: ready comes only from registered occupancy, and a
  // misaligned store is dropped even when the buffer has room.
  always_comb begin
    full          = (count_q == CNT_W'(DEPTH));
    st_ready      = ~full;
    st_misaligned = st_valid & align_misaligned;
    push          = st_valid & st_ready & ~align_misaligned;
    pop           = (state_q == WRITE) & dcache_resp;
    empty         = (count_q == '0);
  end

  // FIFO next state: write at the tail on push, retire the head on pop.
  // Push and pop never target the same slot, because a pop needs a
  // non-empty buffer and a push needs a non-full one.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      entry_d[tail_q].word_addr = st_addr[31:2];
      entry_d[tail_q].wdata     = align_wdata;
      entry_d[tail_q].mbe       = align_mbe;
      valid_d[tail_q]           = 1'b1;
      tail_d                    = tail_q + PTR_W'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Drain FSM next state: leave IDLE once something has been accepted,
  // return to it when the last pending store is retired.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (pop && (count_d == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cache request: the head entry is presented for as long as WRITE lasts,
  // and the bus is held at zero while idle.
  always_comb begin
    dcache_write   = 1'b0;
    dcache_address = 32'h0;
    dcache_wdata   = 32'h0;
    dcache_mbe     = 4'h0;
    if (state_q == WRITE) begin
      dcache_write   = 1'b1;
      dcache_address = {entry_q[head_q].word_addr, 2'b00};
      dcache_wdata   = entry_q[head_q].wdata;
      dcache_mbe     = entry_q[head_q].mbe;
    end
  end

  // Load hazard: any valid entry, or the store entering this cycle, whose
  // word matches the load word. The mask is ignored on purpose.
  always_comb begin
    ld_conflict = push && (st_addr[31:2] == ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].word_addr == ld_addr[31:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end

  // State registers; reset discards every pending store immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule
